// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse cursor block: status bit positions, FSM encoding
// and decoding of the 9-bit signed motion delta.
package ps2_pkg;

    localparam int unsigned BIT_L     = 0;
    localparam int unsigned BIT_R     = 1;
    localparam int unsigned BIT_M     = 2;
    localparam int unsigned BIT_SYNC  = 3;
    localparam int unsigned BIT_XSIGN = 4;
    localparam int unsigned BIT_YSIGN = 5;
    localparam int unsigned BIT_XOVF  = 6;
    localparam int unsigned BIT_YOVF  = 7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_APPLY_X = 3'd2;
    localparam logic [2:0] ST_APPLY_Y = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    // An overflowed axis saturates to the extreme value in the direction of its sign bit.
    function automatic logic signed [8:0] ps2_delta(input logic sign, input logic ovf,
                                                    input logic [7:0] mag);
        if (ovf) begin
            return sign ? signed'(9'h100) : signed'(9'h0FF);
        end
        return signed'({sign, mag});
    endfunction

endpackage

// File: rtl/ps2_axis_clamp.sv
// Combinational single-axis update: scales a signed delta, adds or subtracts it from the
// current position and clamps the result to 0..min(lim_i, LIMIT-1).
module ps2_axis_clamp
    import ps2_pkg::*;
#(
    parameter int unsigned LIMIT = 640,
    parameter int unsigned W     = 11
) (
    input  logic [W-1:0]      pos_i,
    input  logic signed [8:0] delta_i,
    input  logic [1:0]        shift_i,
    input  logic              negate_i,
    input  logic [W-1:0]      lim_i,
    output logic [W-1:0]      pos_o
);

    localparam int unsigned S = W + 4;
    localparam logic signed [S-1:0] LimMax = S'(LIMIT - 1);

    logic signed [S-1:0] pos_s;
    logic signed [S-1:0] step;
    logic signed [S-1:0] sum;
    logic signed [S-1:0] cap;

    always_comb begin
        pos_s = signed'(S'(pos_i));
        step  = S'(delta_i) <<< shift_i;
        sum   = negate_i ? (pos_s - step) : (pos_s + step);
        cap   = signed'(S'(lim_i));
        if (cap > LimMax) begin
            cap = LimMax;
        end
        if (sum[S-1]) begin
            pos_o = '0;
        end else if (sum > cap) begin
            pos_o = cap[W-1:0];
        end else begin
            pos_o = sum[W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// Turns 3-byte PS/2 mouse packets into a screen-clamped absolute cursor position and button
// state, publishing both together with a one-cycle update strobe.
module ps2_mouse_cursor
    import ps2_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SPEED_SHIFT = 0
) (
    input  logic               iCLK_50,
    input  logic               iRST_n,
    input  logic               iPKT_VALID,
    output logic               oPKT_READY,
    input  logic [7:0]         iPKT_STATUS,
    input  logic [7:0]         iPKT_DX,
    input  logic [7:0]         iPKT_DY,
    output logic [COORD_W-1:0] oCUR_X,
    output logic [COORD_W-1:0] oCUR_Y,
    output logic               oLEFBUT,
    output logic               oRIGBUT,
    output logic               oMIDBUT,
    output logic               oUPD,
    output logic               oFRM_ERR,
    output logic [7:0]         oDROP_CNT
);

    localparam logic [COORD_W-1:0] XReset = COORD_W'(H_RES / 2);
    localparam logic [COORD_W-1:0] YReset = COORD_W'(V_RES / 2);
    localparam logic [COORD_W-1:0] XMax   = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] YMax   = COORD_W'(V_RES - 1);
    localparam int unsigned MaxRes = (H_RES > V_RES) ? H_RES : V_RES;

    logic [2:0]               state_q, state_d;
    logic [7:0]               status_q, status_d;
    logic [7:0]               raw_dx_q, raw_dx_d;
    logic [7:0]               raw_dy_q, raw_dy_d;
    logic signed [8:0]        dx_q, dx_d;
    logic signed [8:0]        dy_q, dy_d;
    logic [COORD_W-1:0]       nx_q, nx_d;
    logic [COORD_W-1:0]       ny_q, ny_d;
    logic [COORD_W-1:0]       cur_x_q, cur_x_d;
    logic [COORD_W-1:0]       cur_y_q, cur_y_d;
    logic [2:0]               btn_q, btn_d;
    logic                     upd_q, upd_d;
    logic                     frm_err_q, frm_err_d;
    logic [7:0]               drop_q, drop_d;

    logic                     on_y;
    logic [COORD_W-1:0]       clamp_out;

    assign on_y = (state_q == ST_APPLY_Y);

    // One adder/clamp shared by both axes; the FSM visits X then Y.
    ps2_axis_clamp #(
        .LIMIT (MaxRes),
        .W     (COORD_W)
    ) u_clamp (
        .pos_i    (on_y ? cur_y_q : cur_x_q),
        .delta_i  (on_y ? dy_q : dx_q),
        .shift_i  (2'(SPEED_SHIFT)),
        .negate_i (on_y),
        .lim_i    (on_y ? YMax : XMax),
        .pos_o    (clamp_out)
    );

    assign oPKT_READY = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        raw_dx_d  = raw_dx_q;
        raw_dy_d  = raw_dy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        btn_d     = btn_q;
        upd_d     = 1'b0;
        frm_err_d = 1'b0;
        drop_d    = drop_q;

        if (iPKT_VALID && !oPKT_READY && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (iPKT_VALID) begin
                    status_d = iPKT_STATUS;
                    raw_dx_d = iPKT_DX;
                    raw_dy_d = iPKT_DY;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!status_q[BIT_SYNC]) begin
                    frm_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    dx_d    = ps2_delta(status_q[BIT_XSIGN], status_q[BIT_XOVF], raw_dx_q);
                    dy_d    = ps2_delta(status_q[BIT_YSIGN], status_q[BIT_YOVF], raw_dy_q);
                    state_d = ST_APPLY_X;
                end
            end
            ST_APPLY_X: begin
                nx_d    = clamp_out;
                state_d = ST_APPLY_Y;
            end
            ST_APPLY_Y: begin
                ny_d    = clamp_out;
                state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                cur_x_d = nx_q;
                cur_y_d = ny_q;
                btn_d   = {status_q[BIT_M], status_q[BIT_R], status_q[BIT_L]};
                upd_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            status_q  <= '0;
            raw_dx_q  <= '0;
            raw_dy_q  <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            nx_q      <= XReset;
            ny_q      <= YReset;
            cur_x_q   <= XReset;
            cur_y_q   <= YReset;
            btn_q     <= '0;
            upd_q     <= 1'b0;
            frm_err_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            raw_dx_q  <= raw_dx_d;
            raw_dy_q  <= raw_dy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            btn_q     <= btn_d;
            upd_q     <= upd_d;
            frm_err_q <= frm_err_d;
            drop_q    <= drop_d;
        end
    end

    assign oCUR_X    = cur_x_q;
    assign oCUR_Y    = cur_y_q;
    assign oLEFBUT   = btn_q[0];
    assign oRIGBUT   = btn_q[1];
    assign oMIDBUT   = btn_q[2];
    assign oUPD      = upd_q;
    assign oFRM_ERR  = frm_err_q;
    assign oDROP_CNT = drop_q;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: hand-computed positions, latencies, clamping,
// framing errors, drops and mid-packet reset.
module tb_ps2_mouse_cursor;

    logic        clk;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_status;
    logic [7:0]  pkt_dx;
    logic [7:0]  pkt_dy;
    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic        lefbut;
    logic        rigbut;
    logic        midbut;
    logic        upd;
    logic        frm_err;
    logic [7:0]  drop_cnt;

    int vectors;
    int miscompares;

    ps2_mouse_cursor dut (
        .iCLK_50     (clk),
        .iRST_n      (rst_n),
        .iPKT_VALID  (pkt_valid),
        .oPKT_READY  (pkt_ready),
        .iPKT_STATUS (pkt_status),
        .iPKT_DX     (pkt_dx),
        .iPKT_DY     (pkt_dy),
        .oCUR_X      (cur_x),
        .oCUR_Y      (cur_y),
        .oLEFBUT     (lefbut),
        .oRIGBUT     (rigbut),
        .oMIDBUT     (midbut),
        .oUPD        (upd),
        .oFRM_ERR    (frm_err),
        .oDROP_CNT   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one packet, then watches 8 cycles; reports the cycle (1-based, after the transfer
    // edge) of the first oUPD and oFRM_ERR pulse, -1 if none, and how many oUPD pulses occurred.
    task automatic send_pkt(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                            output int upd_lat, output int err_lat, output int upd_cnt);
        @(negedge clk);
        pkt_valid  = 1'b1;
        pkt_status = st;
        pkt_dx     = dx;
        pkt_dy     = dy;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        upd_lat = -1;
        err_lat = -1;
        upd_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (upd) begin
                upd_cnt++;
                if (upd_lat < 0) upd_lat = c;
            end
            if (frm_err && err_lat < 0) err_lat = c;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pkt_valid  = 1'b0;
        pkt_status = 8'h00;
        pkt_dx     = 8'h00;
        pkt_dy     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (cur_x !== 11'd320 || cur_y !== 11'd240) begin
            $display("FAIL reset_pos: got x=%0d y=%0d, want x=320 y=240", cur_x, cur_y);
            miscompares++;
        end
        vectors++;
        if ({midbut, rigbut, lefbut} !== 3'b000 || upd !== 1'b0 || frm_err !== 1'b0) begin
            $display("FAIL reset_flags: got btn=%b upd=%b err=%b, want 000 0 0",
                     {midbut, rigbut, lefbut}, upd, frm_err);
            miscompares++;
        end
        vectors++;
        if (drop_cnt !== 8'd0 || pkt_ready !== 1'b1) begin
            $display("FAIL reset_ready_drop: got drop=%0d ready=%b, want 0 1", drop_cnt, pkt_ready);
            miscompares++;
        end
    endtask

    task automatic test_basic_motion();
        int ul, el, uc;
        send_pkt(8'h08, 8'h05, 8'h03, ul, el, uc);
        vectors++;
        if (ul !== 4 || uc !== 1) begin
            $display("FAIL basic_latency: got upd at %0d (%0d pulses), want 4 (1)", ul, uc);
            miscompares++;
        end
        vectors++;
        if (cur_x !== 11'd325 || cur_y !== 11'd237 || {midbut, rigbut, lefbut} !== 3'b000) begin
            $display("FAIL basic_pos: got x=%0d y=%0d btn=%b, want 325 237 000",
                     cur_x, cur_y, {midbut, rigbut, lefbut});
            miscompares++;
        end
        // Negative dx with left button held.
        send_pkt(8'h19, 8'hFB, 8'h00, ul, el, uc);
        vectors++;
        if (cur_x !== 11'd320 || cur_y !== 11'd237 || lefbut !== 1'b1 || ul !== 4) begin
            $display("FAIL neg_dx: got x=%0d y=%0d L=%b lat=%0d, want 320 237 1 4",
                     cur_x, cur_y, lefbut, ul);
            miscompares++;
        end
    endtask

    task automatic test_clamp();
        int ul, el, uc;
        send_pkt(8'h48, 8'h10, 8'h00, ul, el, uc);
        vectors++;
        if (cur_x !== 11'd575 || lefbut !== 1'b0) begin
            $display("FAIL xovf_pos: got x=%0d L=%b, want 575 0", cur_x, lefbut);
            miscompares++;
        end
        send_pkt(8'h48, 8'h10, 8'h00, ul, el, uc);
        vectors++;
        if (cur_x !== 11'd639 || cur_y !== 11'd237) begin
            $display("FAIL x_clamp_hi: got x=%0d y=%0d, want 639 237", cur_x, cur_y);
            miscompares++;
        end
        send_pkt(8'h88, 8'h00, 8'h00, ul, el, uc);
        vectors++;
        if (cur_y !== 11'd0 || cur_x !== 11'd639) begin
            $display("FAIL y_clamp_lo: got x=%0d y=%0d, want 639 0", cur_x, cur_y);
            miscompares++;
        end
        send_pkt(8'hA8, 8'h00, 8'h00, ul, el, uc);
        vectors++;
        if (cur_y !== 11'd256) begin
            $display("FAIL yovf_neg: got y=%0d, want 256", cur_y);
            miscompares++;
        end
        send_pkt(8'hA8, 8'h00, 8'h00, ul, el, uc);
        vectors++;
        if (cur_y !== 11'd479) begin
            $display("FAIL y_clamp_hi: got y=%0d, want 479", cur_y);
            miscompares++;
        end
        send_pkt(8'h58, 8'h00, 8'h00, ul, el, uc);
        vectors++;
        if (cur_x !== 11'd383 || cur_y !== 11'd479) begin
            $display("FAIL xovf_neg: got x=%0d y=%0d, want 383 479", cur_x, cur_y);
            miscompares++;
        end
    endtask

    task automatic test_frame_error();
        int ul, el, uc;
        send_pkt(8'h00, 8'h05, 8'h05, ul, el, uc);
        vectors++;
        if (el !== 1 || ul !== -1) begin
            $display("FAIL frm_err_timing: got err at %0d upd at %0d, want 1 and none", el, ul);
            miscompares++;
        end
        vectors++;
        if (cur_x !== 11'd383 || cur_y !== 11'd479 || pkt_ready !== 1'b1) begin
            $display("FAIL frm_err_hold: got x=%0d y=%0d ready=%b, want 383 479 1",
                     cur_x, cur_y, pkt_ready);
            miscompares++;
        end
        // Zero-motion packet after the error still strobes and updates buttons.
        send_pkt(8'h0C, 8'h00, 8'h00, ul, el, uc);
        vectors++;
        if (ul !== 4 || midbut !== 1'b1 || cur_x !== 11'd383 || cur_y !== 11'd479) begin
            $display("FAIL zero_motion: got lat=%0d M=%b x=%0d y=%0d, want 4 1 383 479",
                     ul, midbut, cur_x, cur_y);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int ul;
        @(negedge clk);
        pkt_valid  = 1'b1;
        pkt_status = 8'h08;
        pkt_dx     = 8'h01;
        pkt_dy     = 8'h01;
        @(posedge clk);
        #1;
        pkt_dx = 8'h7F;
        pkt_dy = 8'h7F;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        ul = -1;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (upd && ul < 0) ul = c;
        end
        vectors++;
        if (drop_cnt !== 8'd1) begin
            $display("FAIL drop_cnt: got %0d, want 1", drop_cnt);
            miscompares++;
        end
        vectors++;
        if (cur_x !== 11'd384 || cur_y !== 11'd478 || ul !== 4 || midbut !== 1'b0) begin
            $display("FAIL b2b_pos: got x=%0d y=%0d lat=%0d M=%b, want 384 478 4 0",
                     cur_x, cur_y, ul, midbut);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_packet();
        int seen;
        @(negedge clk);
        pkt_valid  = 1'b1;
        pkt_status = 8'h09;
        pkt_dx     = 8'h10;
        pkt_dy     = 8'h10;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (upd) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            $display("FAIL rst_mid_upd: got %0d upd pulses, want 0", seen);
            miscompares++;
        end
        vectors++;
        if (cur_x !== 11'd320 || cur_y !== 11'd240 || lefbut !== 1'b0 || drop_cnt !== 8'd0) begin
            $display("FAIL rst_mid_state: got x=%0d y=%0d L=%b drop=%0d, want 320 240 0 0",
                     cur_x, cur_y, lefbut, drop_cnt);
            miscompares++;
        end
        vectors++;
        if (pkt_ready !== 1'b1) begin
            $display("FAIL rst_mid_ready: got %b, want 1", pkt_ready);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_motion();
        test_clamp();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
